// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bus for serial_subtractor.
// slave is the subtractor side, master the producer/consumer side.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b), one full-subtract stage per clock.
// Optional SERIAL_SUB_SATURATE_EN clamps diff to zero when the final borrow is set.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] result;

  // Operands shift right so the current bit is always at index 0.
  always_comb begin
    d_bit    = sh_a[0] ^ sh_b[0] ^ bw;
    bw_next  = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & bw);
    res_next = res >> 1;
    res_next[WIDTH-1] = d_bit;
  end

  always_comb begin
`ifdef SERIAL_SUB_SATURATE_EN
    result = bw ? '0 : res;
`else
    result = res;
`endif
  end

  // DONE spends its first cycle publishing the result, giving WIDTH+1 latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sh_a        <= '0;
      sh_b        <= '0;
      res         <= '0;
      cnt         <= '0;
      bw          <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            cnt   <= '0;
            bw    <= 1'b0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          res  <= res_next;
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          bw   <= bw_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            diff_q      <= result;
            borrow_q    <= bw;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
// Define SERIAL_SUB_SATURATE_EN to check the clamping build.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [7:0] exp_diff(input logic [7:0] wrap, input logic brw);
`ifdef SERIAL_SUB_SATURATE_EN
    return brw ? 8'h00 : wrap;
`else
    return wrap;
`endif
  endfunction

  // Accepts one op, checks latency and result; leaves the result unconsumed.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] wrap, input logic brw);
    int lat;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~ta;
    bus.b        = ~tb_v;
    check({tag, ".in_ready_busy"}, bus.in_ready, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 30);
    check({tag, ".latency"}, lat, 9);
    check({tag, ".diff"}, bus.diff, exp_diff(wrap, brw));
    check({tag, ".borrow"}, bus.borrow, brw);
  endtask

  task automatic consume(input string tag, input logic [7:0] held_diff, input logic held_brw);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".valid_drop"}, bus.out_valid, 0);
    check({tag, ".in_ready_back"}, bus.in_ready, 1);
    check({tag, ".diff_kept"}, bus.diff, held_diff);
    check({tag, ".borrow_kept"}, bus.borrow, held_brw);
  endtask

  initial begin
    logic seen;
    pass_cnt      = 0;
    total_cnt     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.diff", bus.diff, 8'h00);
    check("reset.borrow", bus.borrow, 0);
    check("reset.in_ready", bus.in_ready, 1);

    run_op("op35m12", 8'h35, 8'h12, 8'h23, 1'b0);
    consume("op35m12", 8'h23, 1'b0);

    run_op("op12m35", 8'h12, 8'h35, 8'hDD, 1'b1);
    // Stall in DONE: result must hold and new operands must be ignored.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a        = 8'h77;
      bus.b        = 8'h11;
      @(posedge clk); #1;
      check("stall.out_valid", bus.out_valid, 1);
      check("stall.diff", bus.diff, exp_diff(8'hDD, 1'b1));
      check("stall.borrow", bus.borrow, 1);
      check("stall.in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    consume("op12m35", exp_diff(8'hDD, 1'b1), 1'b1);

    run_op("op00m01", 8'h00, 8'h01, 8'hFF, 1'b1);
    consume("op00m01", exp_diff(8'hFF, 1'b1), 1'b1);

    run_op("opFFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    consume("opFFmFF", 8'h00, 1'b0);

    run_op("op5Cm0F", 8'h5C, 8'h0F, 8'h4D, 1'b0);
    consume("op5Cm0F", 8'h4D, 1'b0);

    // Abort an op partway through BUSY with an asynchronous reset.
    bus.a        = 8'h12;
    bus.b        = 8'h35;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort.out_valid", bus.out_valid, 0);
    check("abort.diff", bus.diff, 8'h00);
    check("abort.borrow", bus.borrow, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("abort.in_ready", bus.in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort.no_valid", seen, 0);

    run_op("op80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
    consume("op80m01", 8'h7F, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
